// File: rtl/multiplex_n_1_scan_pkg.sv
// Shared definitions for the N:1 scanning multiplexer: FSM state and mode encodings.
package multiplex_n_1_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/multiplex_next_ch.sv
// Rotating priority encoder: first set bit of mask strictly above ptr, wrapping.
// With ptr = N_CH-1 it yields the lowest set bit; ptr itself is found last.
module multiplex_next_ch #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  always_comb begin
    int unsigned idx;
    nxt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = (32'(ptr) + k) % N_CH;
      if (!found && mask[idx[SEL_W-1:0]]) begin
        found = 1'b1;
        nxt   = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/multiplex_n_1_scan.sv
// N-channel W-bit multiplexer with a registered valid/ready output stage,
// selectable between manual channel select and an auto-scan of enabled channels.
module multiplex_n_1_scan
  import multiplex_n_1_scan_pkg::*;
#(
  parameter int unsigned N_CH    = 16,
  parameter int unsigned W       = 8,
  parameter int unsigned SEL_W   = $clog2(N_CH),
  parameter int unsigned DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   d,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                start,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [N_CH-1:0]     en_mask,
  output logic [W-1:0]        y,
  output logic [SEL_W-1:0]    y_ch,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                busy
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       y_q;
  logic [SEL_W-1:0]   ych_q;
  logic               yv_q;

  logic               slot_free;
  logic               load;
  logic [SEL_W-1:0]   src_idx;
  logic [W-1:0]       src_data;
  logic [SEL_W-1:0]   enc_ptr;
  logic [SEL_W-1:0]   enc_nxt;
  logic               enc_found;

  assign slot_free = !yv_q || y_ready;

  // In IDLE the encoder is seeded with the top index so it returns the lowest enabled channel.
  assign enc_ptr = (state_q == ST_IDLE) ? SEL_W'(N_CH - 1) : ptr_q;

  multiplex_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask  (en_mask),
    .ptr   (enc_ptr),
    .nxt   (enc_nxt),
    .found (enc_found)
  );

  assign src_idx = (state_q == ST_MANUAL) ? sel : ptr_q;

  // Out-of-range indices (non power-of-two N_CH) read as zero.
  always_comb begin
    src_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(src_idx) == i) src_data = d[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_MANUAL) begin
          state_d = ST_MANUAL;
        end else if (start && enc_found) begin
          state_d = ST_WAIT;
          ptr_d   = enc_nxt;
          cnt_d   = '0;
        end
      end
      ST_MANUAL: begin
        if (mode == MODE_SCAN) state_d = ST_IDLE;
        else if (slot_free)    load    = 1'b1;
      end
      ST_WAIT: begin
        if (mode == MODE_MANUAL || !enc_found) state_d = ST_IDLE;
        else if (cnt_q == dwell)               state_d = ST_EMIT;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      ST_EMIT: begin
        if (mode == MODE_MANUAL || !enc_found) begin
          state_d = ST_IDLE;
        end else if (slot_free) begin
          load    = 1'b1;
          ptr_d   = enc_nxt;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ych_q   <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (load) begin
        y_q   <= src_data;
        ych_q <= src_idx;
        yv_q  <= 1'b1;
      end else if (y_ready) begin
        yv_q  <= 1'b0;
      end
    end
  end

  assign y       = y_q;
  assign y_ch    = ych_q;
  assign y_valid = yv_q;
  assign busy    = (state_q == ST_WAIT) || (state_q == ST_EMIT);

endmodule

// File: tb/tb_multiplex_n_1_scan.sv
// Scoreboard bench for multiplex_n_1_scan: a cycle-level reference model predicts
// every load into the output slot; a monitor checks each transfer in order.
module tb_multiplex_n_1_scan;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] d;
  logic [SW-1:0] sel;
  logic          mode;
  logic          start;
  logic [DW-1:0] dwell;
  logic [N-1:0]  en_mask;
  logic [W-1:0]  y;
  logic [SW-1:0] y_ch;
  logic          y_valid;
  logic          y_ready;
  logic          busy;

  always #5 clk = ~clk;

  multiplex_n_1_scan #(
    .N_CH    (N),
    .W       (W),
    .DWELL_W (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .sel     (sel),
    .mode    (mode),
    .start   (start),
    .dwell   (dwell),
    .en_mask (en_mask),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .busy    (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]  v;
    logic [SW-1:0] ch;
  } item_t;

  item_t         sbq[$];
  logic [SW-1:0] xlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nextch(input logic [N-1:0] m, input int p);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (p + k) % N;
      if (m[idx[3:0]]) return idx;
    end
    return p;
  endfunction

  function automatic logic [W-1:0] chd(input int c);
    if (c >= N) return '0;
    return W'(d >> (c * W));
  endfunction

  // Reference model: evaluated between edges on the inputs the DUT will sample next.
  int m_mode = 0;  // 0 idle, 1 manual, 2 scanning
  int m_left = 0;  // edges still to wait before a scan capture is due
  int m_ptr  = 0;
  bit m_full = 1'b0;

  always @(negedge clk) begin : model
    bit    ld;
    bit    sf;
    item_t it;
    ld = 1'b0;
    it.v  = '0;
    it.ch = '0;
    chk("y_valid", 32'(y_valid), 32'(m_full));
    chk("busy", 32'(busy), 32'(m_mode == 2));
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_left = 0; m_full = 1'b0;
      sbq.delete();
    end else begin
      sf = !m_full || y_ready;
      case (m_mode)
        0: begin
          if (!mode) m_mode = 1;
          else if (start && en_mask != '0) begin
            m_mode = 2;
            m_ptr  = nextch(en_mask, N - 1);
            m_left = int'(dwell) + 1;
          end
        end
        1: begin
          if (mode) m_mode = 0;
          else if (sf) begin
            ld = 1'b1; it.v = chd(int'(sel)); it.ch = sel;
          end
        end
        default: begin
          if (!mode || en_mask == '0) m_mode = 0;
          else if (m_left > 0) m_left--;
          else if (sf) begin
            ld = 1'b1; it.v = chd(m_ptr); it.ch = m_ptr[3:0];
            m_ptr  = nextch(en_mask, m_ptr);
            m_left = int'(dwell) + 1;
          end
        end
      endcase
      if (ld) begin
        m_full = 1'b1;
        sbq.push_back(it);
      end else if (y_ready) begin
        m_full = 1'b0;
      end
    end
  end

  logic [W-1:0]  hy;
  logic [SW-1:0] hch;
  bit            held = 1'b0;

  always @(negedge clk) begin : monitor
    item_t it;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && y_valid) begin
        chk("hold_y", 32'(y), 32'(hy));
        chk("hold_ch", 32'(y_ch), 32'(hch));
      end
      if (y_valid && y_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL xfer_unexpected: got y=%0h ch=%0d expected no transfer", y, y_ch);
        end else begin
          it = sbq.pop_front();
          chk("xfer_y", 32'(y), 32'(it.v));
          chk("xfer_ch", 32'(y_ch), 32'(it.ch));
        end
        xlog.push_back(y_ch);
        held = 1'b0;
      end else if (y_valid) begin
        held = 1'b1; hy = y; hch = y_ch;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!y_valid && n < 20) begin
      step();
      n++;
    end
    chk(nm, 32'(y_valid), 32'd1);
  endtask

  task automatic stop_scan();
    mode = 1'b0; start = 1'b0; y_ready = 1'b1;
    step();
    mode = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [SW-1:0] exp3 [5];
    logic [SW-1:0] exp4 [4];
    exp3 = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};
    exp4 = '{4'd0, 4'd15, 4'd0, 4'd15};

    rst = 1'b1; mode = 1'b0; start = 1'b0; sel = '0; dwell = '0;
    en_mask = '0; y_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i*W +: W] = 8'h10 + 8'(i);
    step(); step(); step();
    chk("rst_y", 32'(y), 0);
    chk("rst_ych", 32'(y_ch), 0);
    chk("rst_valid", 32'(y_valid), 0);
    chk("rst_busy", 32'(busy), 0);

    // Manual sweep, one-cycle latency
    rst = 1'b0;
    step();
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      step();
      chk("man_y", 32'(y), 32'(8'h10 + s));
      chk("man_ch", 32'(y_ch), 32'(s));
    end

    // Manual backpressure
    sel = 4'd3;
    step();
    y_ready = 1'b0; sel = 4'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold", 32'(y), 32'h13);
    end
    y_ready = 1'b1;
    step();
    chk("bp_next", 32'(y), 32'h17);

    // Scan timing and order
    mode = 1'b1;
    step();
    en_mask = 16'h8421; dwell = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("t3_early", 32'(y_valid), 0);
    step();
    chk("t3_first", 32'(y_valid), 1);
    chk("t3_ch0", 32'(y_ch), 32'(exp3[0]));
    for (int j = 1; j < 5; j++) begin
      step(); step(); step(); step();
      chk("t3_valid", 32'(y_valid), 1);
      chk("t3_ch", 32'(y_ch), 32'(exp3[j]));
    end
    stop_scan();

    // Scan wrap with stall
    xlog.delete();
    en_mask = 16'h8001; dwell = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t4_first");
    y_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    y_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t4_count", 32'(xlog.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < xlog.size()) chk("t4_order", 32'(xlog[i]), 32'(exp4[i]));
    stop_scan();

    // Mask cleared mid-scan
    en_mask = 16'h8421; dwell = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t5_first");
    y_ready = 1'b0; en_mask = '0;
    step();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_pending", 32'(y_valid), 1);
    y_ready = 1'b1;
    step();
    chk("t5_drained", 32'(y_valid), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_nostart", 32'(busy), 0);
    step();
    chk("t5_nostart2", 32'(busy), 0);

    // Reset while stalled in capture
    en_mask = 16'h8421; dwell = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t6_first");
    y_ready = 1'b0;
    step(); step();
    chk("t6_busy", 32'(busy), 1);
    chk("t6_valid", 32'(y_valid), 1);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", 32'(y_valid), 0);
    chk("t6_rst_y", 32'(y), 0);
    chk("t6_rst_ch", 32'(y_ch), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rst = 1'b0; y_ready = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("t6_restart");
    chk("t6_restart_ch", 32'(y_ch), 0);
    stop_scan();

    // Randomised phases
    for (int ph = 0; ph < 6; ph++) begin
      dwell = DW'($urandom_range(0, 3));
      en_mask = 16'($urandom);
      for (int c = 0; c < 60; c++) begin
        d       = {$urandom, $urandom, $urandom, $urandom};
        sel     = SW'($urandom);
        y_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) mode = ~mode;
        start   = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0)
          en_mask = ($urandom_range(0, 3) == 0) ? '0 : 16'($urandom);
        rst     = ($urandom_range(0, 99) == 0);
        step();
      end
      rst = 1'b0;
      stop_scan();
    end

    y_ready = 1'b1; mode = 1'b1; start = 1'b0;
    step(); step(); step();
    chk("sb_left", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
